// File: rtl/neigh_gen.sv
// Raster-to-neighbourhood front end: two line buffers produce {top, bot, left, right} per pixel.
// Optional build macro NEIGH_ZERO_PAD_EN: out-of-frame neighbours become 0 instead of the center value.
module neigh_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic               i_ready,
  output logic               o_valid,
  output logic [4*PIX_W-1:0] pixel,
  output logic               o_eol,
  output logic               o_last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;

  // line_cur holds the row above the incoming one, line_prev the row above that.
  logic [PIX_W-1:0] line_cur  [IMG_W];
  logic [PIX_W-1:0] line_prev [IMG_W];
  logic [PIX_W-1:0] left_q;

  logic               o_valid_q, eol_q, last_q;
  logic [4*PIX_W-1:0] pixel_q;

  logic               xfer, emit;
  logic [XW-1:0]      right_idx;
  logic [PIX_W-1:0]   center, pad;
  logic [PIX_W-1:0]   top_n, bot_n, left_n, right_n;
  logic               top_oof, bot_oof, left_oof, right_oof;

  assign i_ready = (state_q != S_FLUSH);
  assign xfer    = i_valid && (state_q != S_FLUSH);
  assign emit    = ((state_q == S_RUN) && xfer) || (state_q == S_FLUSH);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      S_FILL: if (xfer) begin
        if (x_q == X_LAST) begin
          x_d     = '0;
          y_d     = y_q + 1'b1;
          state_d = S_RUN;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_RUN: if (xfer) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = S_FLUSH;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (x_q == X_LAST) begin
          x_d     = '0;
          state_d = S_FILL;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // In FLUSH the column counter walks the stored last row; no writes happen then.
  always_comb begin
    right_idx = (x_q == X_LAST) ? x_q : x_q + 1'b1;
    center    = line_cur[x_q];
    top_oof   = (state_q == S_RUN) && (y_q == Y_ONE);
    bot_oof   = (state_q == S_FLUSH);
    left_oof  = (x_q == '0);
    right_oof = (x_q == X_LAST);
`ifdef NEIGH_ZERO_PAD_EN
    pad       = '0;
`else
    pad       = center;
`endif
    top_n     = top_oof   ? pad : line_prev[x_q];
    bot_n     = bot_oof   ? pad : i_pixel;
    left_n    = left_oof  ? pad : left_q;
    right_n   = right_oof ? pad : line_cur[right_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      x_q       <= '0;
      y_q       <= '0;
      o_valid_q <= 1'b0;
      pixel_q   <= '0;
      eol_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      o_valid_q <= emit;
      eol_q     <= emit && right_oof;
      last_q    <= emit && bot_oof && right_oof;
      if (emit) pixel_q <= {top_n, bot_n, left_n, right_n};
    end
  end

  // NOTE: line buffers are deliberately not reset; row 0 of every frame overwrites them before use.
  always_ff @(posedge clk) begin
    if (xfer) begin
      line_prev[x_q] <= center;
      line_cur[x_q]  <= i_pixel;
    end
    // left_q carries the center of the previous column, since line_cur[x-1] is already overwritten.
    if (xfer || (state_q == S_FLUSH)) left_q <= center;
  end

  assign o_valid = o_valid_q;
  assign pixel   = pixel_q;
  assign o_eol   = eol_q;
  assign o_last  = last_q;

endmodule
